// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant into a fixed
// IDLE/ACCESS/RESP transaction with byte/half/word lane steering and alignment checks.

module dmem_arbiter_rsp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             err,
  input  logic [WIDTH-1:0] rdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_rdata
);
  logic             valid_d, valid_q, err_d, err_q;
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // Response fields are only non-zero during the one-cycle pulse.
  always_comb begin
    valid_d = load;
    err_d   = load & err;
    rdata_d = load ? rdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
endmodule

module dmem_arbiter #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m0_req_valid,
  output logic                     m0_req_ready,
  input  logic                     m0_we,
  input  logic [31:0]              m0_addr,
  input  logic [1:0]               m0_size,
  input  logic [WIDTH-1:0]         m0_wdata,
  output logic                     m0_rsp_valid,
  output logic [WIDTH-1:0]         m0_rsp_rdata,
  output logic                     m0_rsp_err,
  input  logic                     m1_req_valid,
  output logic                     m1_req_ready,
  input  logic                     m1_we,
  input  logic [31:0]              m1_addr,
  input  logic [1:0]               m1_size,
  input  logic [WIDTH-1:0]         m1_wdata,
  output logic                     m1_rsp_valid,
  output logic [WIDTH-1:0]         m1_rsp_rdata,
  output logic                     m1_rsp_err,
  output logic                     mem_we0,
  output logic [$clog2(DEPTH)-1:0] mem_wr_addr0,
  output logic [$clog2(DEPTH)-1:0] mem_rd_addr0,
  output logic [3:0]               mem_wr_strb,
  output logic [3:0]               mem_rd_strb,
  output logic [WIDTH-1:0]         mem_wr_din0,
  input  logic [WIDTH-1:0]         mem_rd_dout0
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state_d, state_q;
  logic             ptr_d, ptr_q, gid_d, gid_q, we_d, we_q;
  logic [31:0]      addr_d, addr_q;
  logic [1:0]       size_d, size_q;
  logic [WIDTH-1:0] wdata_d, wdata_q, rdata_d, rdata_q;

  logic [1:0]       req_valid, gnt, rsp_load;
  logic [1:0]       off;
  logic [AW-1:0]    idx;
  logic             err_c, acc;
  logic [3:0]       strb;
  logic [WIDTH-1:0] shifted, ld_data;

  assign req_valid = {m1_req_valid, m0_req_valid};
  assign off       = addr_q[1:0];
  assign idx       = addr_q[AW+1:2];

  // Pointer names the preferred requester; the other one wins only when it is alone.
  always_comb begin
    gnt = 2'b00;
    if (state_q == S_IDLE && !reset) begin
      if (req_valid[ptr_q])       gnt[ptr_q]  = 1'b1;
      else if (req_valid[~ptr_q]) gnt[~ptr_q] = 1'b1;
    end
  end

  assign m0_req_ready = gnt[0];
  assign m1_req_ready = gnt[1];

  always_comb begin
    err_c = 1'b0;
    strb  = 4'b0000;
    case (size_q)
      2'b00: strb = 4'b0001 << off;
      2'b01: begin strb = 4'b0011 << off; err_c = off[0]; end
      2'b10: begin strb = 4'b1111; err_c = (off != 2'b00); end
      default: err_c = 1'b1;
    endcase
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH)) err_c = 1'b1;
  end

  always_comb begin
    shifted = mem_rd_dout0 >> {off, 3'b000};
    case (size_q)
      2'b00:   ld_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      2'b01:   ld_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // Memory side is purely a function of state, so an async reset kills it at once.
  assign acc          = (state_q == S_ACCESS) && !err_c;
  assign mem_we0      = acc && we_q;
  assign mem_wr_addr0 = acc ? idx : '0;
  assign mem_rd_addr0 = acc ? idx : '0;
  assign mem_wr_strb  = (acc && we_q) ? strb : 4'b0000;
  assign mem_rd_strb  = (acc && !we_q) ? strb : 4'b0000;
  assign mem_wr_din0  = (acc && we_q) ? (wdata_q << {off, 3'b000}) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (|gnt) begin
        state_d = S_ACCESS;
        gid_d   = gnt[1];
        ptr_d   = ~gnt[1];
        we_d    = gnt[1] ? m1_we    : m0_we;
        addr_d  = gnt[1] ? m1_addr  : m0_addr;
        size_d  = gnt[1] ? m1_size  : m0_size;
        wdata_d = gnt[1] ? m1_wdata : m0_wdata;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        rdata_d = (we_q || err_c) ? '0 : ld_data;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gid_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  logic [1:0]            rsp_v, rsp_e;
  logic [1:0][WIDTH-1:0] rsp_d;

  always_comb begin
    rsp_load = 2'b00;
    if (state_q == S_RESP) rsp_load[gid_q] = 1'b1;
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    dmem_arbiter_rsp #(.WIDTH(WIDTH)) u_rsp (
      .clk       (clk),
      .reset     (reset),
      .load      (rsp_load[i]),
      .err       (err_c),
      .rdata     (rdata_q),
      .rsp_valid (rsp_v[i]),
      .rsp_err   (rsp_e[i]),
      .rsp_rdata (rsp_d[i])
    );
  end

  assign m0_rsp_valid = rsp_v[0];
  assign m0_rsp_err   = rsp_e[0];
  assign m0_rsp_rdata = rsp_d[0];
  assign m1_rsp_valid = rsp_v[1];
  assign m1_rsp_err   = rsp_e[1];
  assign m1_rsp_rdata = rsp_d[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares them; memory-side lanes checked in ACCESS.

module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v[2], we[2], rdy[2], rv[2], rerr[2];
  logic [31:0] addr[2], wd[2], rd[2];
  logic [1:0]  sz[2];
  logic        mem_we0;
  logic [6:0]  mem_wr_addr0, mem_rd_addr0;
  logic [3:0]  mem_wr_strb, mem_rd_strb;
  logic [31:0] mem_wr_din0, mem_rd_dout0;

  logic [31:0] mem [0:127];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t q0[$], q1[$];
  int   glog[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we0)
      for (int b = 0; b < 4; b++)
        if (mem_wr_strb[b]) mem[mem_wr_addr0][8*b +: 8] <= mem_wr_din0[8*b +: 8];
  end
  assign mem_rd_dout0 = mem[mem_rd_addr0];

  dmem_arbiter #(.DEPTH(128), .WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(v[0]), .m0_req_ready(rdy[0]), .m0_we(we[0]), .m0_addr(addr[0]),
    .m0_size(sz[0]), .m0_wdata(wd[0]), .m0_rsp_valid(rv[0]), .m0_rsp_rdata(rd[0]),
    .m0_rsp_err(rerr[0]),
    .m1_req_valid(v[1]), .m1_req_ready(rdy[1]), .m1_we(we[1]), .m1_addr(addr[1]),
    .m1_size(sz[1]), .m1_wdata(wd[1]), .m1_rsp_valid(rv[1]), .m1_rsp_rdata(rd[1]),
    .m1_rsp_err(rerr[1]),
    .mem_we0(mem_we0), .mem_wr_addr0(mem_wr_addr0), .mem_rd_addr0(mem_rd_addr0),
    .mem_wr_strb(mem_wr_strb), .mem_rd_strb(mem_rd_strb), .mem_wr_din0(mem_wr_din0),
    .mem_rd_dout0(mem_rd_dout0)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Monitor: grant log, one-hot ready, and response scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rdy[0] || rdy[1]) chk("ready_onehot", {31'd0, rdy[0] & rdy[1]}, 32'd0);
    if (rdy[0]) glog.push_back(0);
    else if (rdy[1]) glog.push_back(1);
    for (int i = 0; i < 2; i++) begin
      if (rv[i]) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: requester %0d got rsp_valid, expected none", i);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("rsp_rdata", rd[i], e.rdata);
          chk("rsp_err", {31'd0, rerr[i]}, {31'd0, e.err});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] estrb, input logic [31:0] edin,
                       input logic [31:0] erd, input logic eerr);
    bit   ok = 0;
    exp_t e;
    @(negedge clk);
    v[i] = 1'b1; we[i] = w; addr[i] = a; sz[i] = s; wd[i] = d;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (rdy[i]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      v[i] = 1'b0;
      checks++; errors++;
      $display("FAIL grant_timeout: requester %0d got no ready, expected one within 60 cycles", i);
      return;
    end
    e.rdata = erd; e.err = eerr; e.cyc = cyc + 3;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1;
    v[i] = 1'b0; we[i] = ~w; addr[i] = 32'hFFFF_FFFC; sz[i] = 2'b11; wd[i] = $urandom;
    @(negedge clk);
    #1;
    if (eerr) begin
      chk("err_we0", {31'd0, mem_we0}, 32'd0);
      chk("err_strb", {24'd0, mem_wr_strb, mem_rd_strb}, 32'd0);
    end else begin
      chk("mem_addr", {25'd0, mem_rd_addr0}, {25'd0, a[8:2]});
      chk("mem_we0", {31'd0, mem_we0}, {31'd0, w});
      if (w) begin
        chk("wr_strb", {28'd0, mem_wr_strb}, {28'd0, estrb});
        chk("wr_din", mem_wr_din0, edin);
        chk("wr_addr", {25'd0, mem_wr_addr0}, {25'd0, a[8:2]});
      end else begin
        chk("rd_strb", {28'd0, mem_rd_strb}, {28'd0, estrb});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b1; we[i] = 1'b1; addr[i] = 32'h8; sz[i] = 2'b10; wd[i] = 32'hFFFF_FFFF;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", {30'd0, rdy[1], rdy[0]}, 32'd0);
    chk("reset_rsp", {28'd0, rv[1], rv[0], rerr[1], rerr[0]}, 32'd0);
    chk("reset_rdata", rd[0] | rd[1], 32'd0);
    chk("reset_mem", {mem_we0, mem_wr_strb, mem_rd_strb, mem_wr_addr0, mem_rd_addr0}, 32'd0);
    chk("reset_din", mem_wr_din0, 32'd0);
    v[0] = 1'b0; v[1] = 1'b0;
    preload(7'd1, 32'hDEAD_BEEF);
    preload(7'd2, 32'hDEAD_BEEF);
    preload(7'd3, 32'h1111_1111);
    @(negedge clk);
    reset = 1'b0;

    // Loads and lane steering
    issue(0, 0, 32'h8, 2'b10, 32'h0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0);
    issue(0, 0, 32'h7, 2'b00, 32'h0, 4'b1000, 32'h0, 32'h0000_00DE, 0);
    issue(1, 0, 32'h4, 2'b00, 32'h0, 4'b0001, 32'h0, 32'h0000_00EF, 0);
    issue(1, 1, 32'h6, 2'b01, 32'h0000_ABCD, 4'b1100, 32'hABCD_0000, 32'h0, 0);
    issue(0, 0, 32'h6, 2'b01, 32'h0, 4'b1100, 32'h0, 32'h0000_ABCD, 0);
    issue(0, 0, 32'h4, 2'b01, 32'h0, 4'b0011, 32'h0, 32'h0000_BEEF, 0);
    issue(0, 1, 32'h5, 2'b00, 32'h0000_0055, 4'b0010, 32'h0000_5500, 32'h0, 0);
    issue(1, 0, 32'h4, 2'b10, 32'h0, 4'b1111, 32'h0, 32'hABCD_55EF, 0);

    // Error cases: misaligned, illegal size, out of range
    issue(0, 0, 32'h2, 2'b10, 32'h0, 4'b0, 32'h0, 32'h0, 1);
    issue(1, 0, 32'h1, 2'b01, 32'h0, 4'b0, 32'h0, 32'h0, 1);
    issue(0, 0, 32'h0, 2'b11, 32'h0, 4'b0, 32'h0, 32'h0, 1);
    issue(1, 1, 32'h200, 2'b10, 32'hFFFF_FFFF, 4'b0, 32'h0, 32'h0, 1);
    repeat (3) @(negedge clk);
    chk("err_no_write", mem[0], 32'h0);

    // Store then load across requesters
    issue(1, 1, 32'h14, 2'b10, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'h0, 0);
    issue(0, 0, 32'h14, 2'b10, 32'h0, 4'b1111, 32'h0, 32'h1234_5678, 0);
    repeat (3) @(negedge clk);

    // Reset during the ACCESS of an m0 store; leaves pointer at m1 unless reset clears it
    v[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'hC; sz[0] = 2'b10; wd[0] = 32'hCAFE_F00D;
    #1;
    chk("abort_ready", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk);
    #1 v[0] = 1'b0;
    chk("abort_we0_before", {31'd0, mem_we0}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_we0_after", {31'd0, mem_we0}, 32'd0);
    chk("abort_strb", {28'd0, mem_wr_strb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_mem", mem[3], 32'h1111_1111);

    // Contention: both valid, grants alternate starting at m0
    glog.delete();
    fork
      begin
        issue(0, 0, 32'h8, 2'b10, 32'h0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0);
        issue(0, 0, 32'h9, 2'b00, 32'h0, 4'b0010, 32'h0, 32'h0000_00BE, 0);
      end
      begin
        issue(1, 0, 32'h14, 2'b10, 32'h0, 4'b1111, 32'h0, 32'h1234_5678, 0);
        issue(1, 0, 32'h16, 2'b01, 32'h0, 4'b1100, 32'h0, 32'h0000_1234, 0);
      end
    join
    for (int k = 0; k < 4; k++)
      chk("grant_order", (k < glog.size()) ? glog[k] : 99, k % 2);

    repeat (6) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning data memory depth in 32-bit words.
REQ-002 SHALL have parameter WIDTH, default 32, meaning memory word width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port m<i>_req_valid  input  1  meaning requester i (i=0 core LSU, i=1 DMA/debug) holds a request.
REQ-006 SHALL have port m<i>_req_ready  output  1  meaning the request of requester i is accepted this cycle.
REQ-007 SHALL have port m<i>_we  input  1  meaning the request is a store (1) or a load (0).
REQ-008 SHALL have port m<i>_addr  input  32  meaning the byte address.
REQ-009 SHALL have port m<i>_size  input  2  meaning access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 SHALL have port m<i>_wdata  input  32  meaning store data, right-aligned.
REQ-011 SHALL have port m<i>_rsp_valid  output  1  meaning a one-cycle response pulse to requester i.
REQ-012 SHALL have port m<i>_rsp_rdata  output  32  meaning load data, right-aligned and zero-extended; 0 for stores and errors.
REQ-013 SHALL have port m<i>_rsp_err  output  1  meaning the access was rejected, valid with rsp_valid.
REQ-014 SHALL have ports mem_we0 (output, 1), mem_wr_addr0 (output, $clog2(DEPTH)), mem_rd_addr0 (output, $clog2(DEPTH)), mem_wr_strb (output, 4), mem_rd_strb (output, 4), mem_wr_din0 (output, 32) and mem_rd_dout0 (input, 32), meaning the data memory port; memory read is combinational and in-lane.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCESS and RESP; transitions are IDLE->ACCESS on a grant, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-016 SHALL assert m<i>_req_ready combinationally only in IDLE, only to the arbitration winner, and for at most one requester per cycle.
REQ-017 SHALL arbitrate round-robin: the priority pointer resets to m0, and after any grant to mi the pointer moves to the other requester; a single valid requester always wins.
REQ-018 SHALL latch we, addr, size, wdata and the grant id on the accept edge; the requester may change its inputs thereafter.
REQ-019 SHALL compute word index = addr[31:2] and offset = addr[1:0].
REQ-020 SHALL generate strobes as follows: byte -> 4'b0001<<off; half -> 4'b0011<<off; word -> 4'b1111.
REQ-021 SHALL flag an error for any of: half with off[0]=1, word with off!=0, size=11, or word index >= DEPTH.
REQ-022 SHALL, in ACCESS with no error, drive mem_rd_addr0 = mem_wr_addr0 = index; on a store drive mem_we0=1, mem_wr_strb = strobe and mem_wr_din0 = wdata<<(8*off); on a load drive mem_rd_strb = strobe.
REQ-023 SHALL hold all mem_* outputs at 0 outside ACCESS and on error, so no memory side effect occurs on error.
REQ-024 SHALL, for a load in ACCESS, register (mem_rd_dout0>>(8*off)) masked to size (8/16/32 bits) into the response data register.
REQ-025 SHALL pulse rsp_valid for exactly one cycle in RESP, to the granted requester only, with rsp_err per REQ-021.
REQ-026 SHALL have a fixed latency: accept at edge T gives the memory access in cycle T..T+1 and rsp_valid high in cycle T+2..T+3; throughput is one request per 3 cycles.
REQ-027 SHALL ignore a request arriving during ACCESS or RESP until IDLE; such a request is not lost while valid is held.

Reset
REQ-028 SHALL, while reset=1, asynchronously force state=IDLE, pointer=m0, all rsp_valid/rsp_err/rsp_rdata=0, all req_ready=0 and all mem_* outputs=0.
REQ-029 SHALL, on reset asserted mid-ACCESS, drop mem_we0 immediately; no response is generated for the aborted request.

Verification
REQ-030 Single load: m0 load word at addr 0x8 with mem word 2 = 0xDEADBEEF -> rd_strb 1111, rd_addr0 2, rsp_rdata 0xDEADBEEF, err 0, rsp_valid at T+2.
REQ-031 Byte/half lanes: load byte at 0x7 -> rd_strb 1000, rdata 0x000000DE; store half 0xABCD at 0x6 -> wr_strb 1100, wr_din0 0xABCD0000.
REQ-032 Contention: m0 and m1 both valid continuously after reset -> grants alternate m0, m1, m0, m1, with each rsp_valid delivered to the correct requester only.
REQ-033 Errors: word at 0x2, half at 0x1, size 11, and addr 0x200 with DEPTH=128 -> rsp_err 1, rdata 0, mem_we0 and strobes stay 0.
REQ-034 Reset mid-op: assert reset during the ACCESS of a store -> mem_we0 falls immediately, no rsp_valid, and the memory word is unchanged.
REQ-035 Store-then-load: m1 stores 0x12345678 at word 5, m0 loads word 5 -> m0 receives 0x12345678.
